// File: rtl/ltc2220_capture.sv
// Triggered pre/post capture of one LTC2220 channel (offset binary -> two's complement),
// stored in a circular RAM and streamed out oldest-first over valid/ready.
module ltc2220_capture #(
  parameter int DEPTH = 1024,
  parameter int PRE   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ad_data_in,
  input  logic        arm,
  input  logic        force_trig,
  input  logic [11:0] trig_level,
  input  logic        trig_edge,
  output logic        busy,
  output logic        done,
  output logic [11:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last
);
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int POST_N = DEPTH - PRE;

  typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST, READOUT} state_t;
  state_t state, state_nxt;

  logic [11:0]   s1, s2, prev;
  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_addr, trig_addr, rd_addr, rd_base;
  logic [CW-1:0] cnt, iss_left;
  logic [11:0]   ram_q, sk_data;
  logic          q_vld, q_last, sk_vld, sk_last;
  logic          we, hit, start_rd, trig, rise, fall;
  logic          pop, take, issue;
  logic [1:0]    occ;

  always_comb begin
    rise = ($signed(prev) < $signed(trig_level)) && ($signed(s2) >= $signed(trig_level));
    fall = ($signed(prev) > $signed(trig_level)) && ($signed(s2) <= $signed(trig_level));
    trig = (trig_edge ? fall : rise) | force_trig;
  end

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    hit       = 1'b0;
    start_rd  = 1'b0;
    case (state)
      IDLE:      if (arm) state_nxt = PRE_FILL;
      PRE_FILL: begin
        we = 1'b1;
        if (cnt == CW'(PRE - 1)) state_nxt = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        we = 1'b1;
        if (trig) begin
          hit = 1'b1;
          // A one-sample post window completes on the trigger sample itself.
          if (POST_N == 1) begin
            state_nxt = READOUT;
            start_rd  = 1'b1;
          end else begin
            state_nxt = POST;
          end
        end
      end
      POST: begin
        we = 1'b1;
        if (cnt == CW'(POST_N - 1)) begin
          state_nxt = READOUT;
          start_rd  = 1'b1;
        end
      end
      READOUT:   if (pop && rd_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST);
  assign done    = (state == READOUT);
  assign rd_base = (hit ? wr_addr : trig_addr) - AW'(PRE);

  // Read issue keeps output + skid + in-flight RAM read at no more than two entries.
  assign pop   = rd_valid && rd_ready;
  assign take  = !rd_valid || pop;
  assign occ   = {1'b0, rd_valid & ~pop} + {1'b0, sk_vld} + {1'b0, q_vld};
  assign issue = (state == READOUT) && (iss_left != '0) && (occ < 2'd2);

  always_ff @(posedge clk) begin
    if (we)    mem[wr_addr] <= s2;
    if (issue) ram_q        <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      cnt       <= '0;
      wr_addr   <= '0;
      trig_addr <= '0;
      rd_addr   <= '0;
      iss_left  <= '0;
      q_vld     <= 1'b0;
      q_last    <= 1'b0;
      sk_vld    <= 1'b0;
      sk_last   <= 1'b0;
      sk_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else begin
      state <= state_nxt;
      s1    <= ad_data_in;
      s2    <= {~s1[11], s1[10:0]};
      prev  <= s2;

      if (state == IDLE && arm) cnt <= '0;
      else if (we)              cnt <= (state == WAIT_TRIG) ? CW'(1) : cnt + 1'b1;
      if (we)  wr_addr   <= wr_addr + 1'b1;
      if (hit) trig_addr <= wr_addr;

      if (start_rd) begin
        rd_addr  <= rd_base;
        iss_left <= CW'(DEPTH);
      end else if (issue) begin
        rd_addr  <= rd_addr + 1'b1;
        iss_left <= iss_left - 1'b1;
      end
      q_vld <= issue;
      if (issue) q_last <= (iss_left == CW'(1));

      if (take) begin
        if (sk_vld) begin
          rd_valid <= 1'b1;
          rd_data  <= sk_data;
          rd_last  <= sk_last;
          sk_vld   <= q_vld;
          sk_data  <= ram_q;
          sk_last  <= q_last;
        end else if (q_vld) begin
          rd_valid <= 1'b1;
          rd_data  <= ram_q;
          rd_last  <= q_last;
        end else begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end else if (q_vld) begin
        sk_vld  <= 1'b1;
        sk_data <= ram_q;
        sk_last <= q_last;
      end
    end
  end
endmodule
